// File: rtl/rv_fetch_pkg.sv
// Shared constants and types for the uRV instruction fetch stage.
package rv_fetch_pkg;

    localparam int RV_FETCH_MAX_OUTSTANDING = 2;
    localparam int RV_INSN_BYTES            = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/rv_fetch_if.sv
// Fetch-stage bus bundle: instruction memory port, decode handoff and execute redirect.
interface rv_fetch_if;

    logic [31:0] im_addr_o;
    logic        im_rd_o;
    logic [31:0] im_data_i;
    logic        im_valid_i;
    logic [31:0] f_ir_o;
    logic [31:0] f_pc_o;
    logic        f_valid_o;
    logic        f_stall_i;
    logic        x_bra_i;
    logic [31:0] x_bra_target_i;

    modport master (
        output im_addr_o, im_rd_o, f_ir_o, f_pc_o, f_valid_o,
        input  im_data_i, im_valid_i, f_stall_i, x_bra_i, x_bra_target_i
    );

    modport slave (
        input  im_addr_o, im_rd_o, f_ir_o, f_pc_o, f_valid_o,
        output im_data_i, im_valid_i, f_stall_i, x_bra_i, x_bra_target_i
    );

endinterface

// File: rtl/rv_fetch_fifo.sv
// Two-entry {pc, ir} buffer between instruction memory and decode.
module rv_fetch_fifo
    import rv_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t din,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [1:0]   count,
    output logic         empty,
    output logic         full
);

    fetch_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            // flush beats a same-cycle push/pop; stale head data stays but is masked by empty
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/rv_fetch.sv
// uRV fetch stage: PC generation, credit-limited pipelined reads, stale-response discard.
module rv_fetch
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0
) (
    input  logic      clk_i,
    input  logic      rst_i,
    rv_fetch_if.master bus
);

    logic [31:0]  fetch_pc;
    logic [31:0]  resp_pc;
    logic [1:0]   outstanding;
    logic [1:0]   discard;
    fetch_entry_t head;
    logic [1:0]   count;
    logic         empty;
    logic         full;
    logic         pop;
    logic         push;
    logic         issue;
    logic [2:0]   credit_used;

    assign pop  = !empty && !bus.f_stall_i;
    assign push = bus.im_valid_i && (discard == 2'd0) && !bus.x_bra_i;

    // reads in flight plus buffered words must leave room for every response
    assign credit_used = 3'(outstanding) + 3'(count) - 3'(pop);
    assign issue = !rst_i && !bus.x_bra_i &&
                   (credit_used < 3'(RV_FETCH_MAX_OUTSTANDING));

    assign bus.im_rd_o   = issue;
    assign bus.im_addr_o = fetch_pc;
    assign bus.f_valid_o = !empty;
    assign bus.f_ir_o    = head.ir;
    assign bus.f_pc_o    = head.pc;

    rv_fetch_fifo u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .din   ('{pc: resp_pc, ir: bus.im_data_i}),
        .pop   (pop),
        .flush (bus.x_bra_i),
        .head  (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc    <= RESET_VECTOR;
            resp_pc     <= RESET_VECTOR;
            outstanding <= 2'd0;
            discard     <= 2'd0;
        end else begin
            outstanding <= outstanding + 2'(issue) - 2'(bus.im_valid_i);
            if (bus.x_bra_i) begin
                fetch_pc <= word_align(bus.x_bra_target_i);
                resp_pc  <= word_align(bus.x_bra_target_i);
                // everything still in flight after this cycle belongs to the old path
                discard  <= outstanding - 2'(bus.im_valid_i);
            end else begin
                if (issue)
                    fetch_pc <= fetch_pc + 32'(RV_INSN_BYTES);
                if (push)
                    resp_pc <= resp_pc + 32'(RV_INSN_BYTES);
                if (bus.im_valid_i && discard != 2'd0)
                    discard <= discard - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_rv_fetch.sv
// Randomized bench for rv_fetch: in-order memory with random latency, expected instruction stream model.
module tb_rv_fetch;
    import rv_fetch_pkg::*;

    localparam logic [31:0] RV = 32'h100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv_fetch_if bus();
    rv_fetch #(.RESET_VECTOR(RV)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int n_vec = 0, n_err = 0, cyc = 0, pops = 0;
    logic        rst_v = 1'b1, stall_v = 1'b0, bra_v = 1'b0;
    logic [31:0] tgt_v = '0;
    int          lmin = 1, lmax = 1, last_due = 0;
    logic [31:0] rq_addr[$];
    int          rq_due[$];
    logic [31:0] exp_pc = RV;
    logic        pv_valid = 1'b0, pv_stall = 1'b0, pv_kill = 1'b1;
    logic [31:0] pv_pc = '0, pv_ir = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // one clock: drive at negedge, model memory, sample mid-cycle
    task automatic step();
        int lat;
        @(negedge clk);
        rst                = rst_v;
        bus.f_stall_i      = stall_v;
        bus.x_bra_i        = bra_v;
        bus.x_bra_target_i = tgt_v;
        if (!rst_v && rq_due.size() > 0 && rq_due[0] <= cyc) begin
            bus.im_valid_i = 1'b1;
            bus.im_data_i  = mem_word(rq_addr[0]);
            void'(rq_addr.pop_front());
            void'(rq_due.pop_front());
        end else begin
            bus.im_valid_i = 1'b0;
            bus.im_data_i  = $urandom;
        end
        #2;
        if (rst_v) begin
            chk("rst_rd", bus.im_rd_o, 0);
            rq_addr.delete();
            rq_due.delete();
            last_due = cyc;
            exp_pc   = RV;
            pv_kill  = 1'b1;
        end else begin
            if (pv_valid && pv_stall && !pv_kill) begin
                chk("hold_vld", bus.f_valid_o, 1);
                chk("hold_word", {bus.f_pc_o, bus.f_ir_o}, {pv_pc, pv_ir});
            end
            if (bus.f_valid_o && !stall_v) begin
                chk("pc", bus.f_pc_o, exp_pc);
                chk("ir", bus.f_ir_o, mem_word(exp_pc));
                exp_pc += 32'd4;
                pops++;
            end
            if (bra_v)
                chk("bra_rd", bus.im_rd_o, 0);
            if (bus.im_rd_o) begin
                lat = $urandom_range(lmax, lmin);
                last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                rq_addr.push_back(bus.im_addr_o);
                rq_due.push_back(last_due);
                chk("inflight", rq_addr.size() <= 2, 1);
            end
            if (bra_v)
                exp_pc = tgt_v & ~32'h3;
            pv_kill = bra_v;
        end
        pv_valid = bus.f_valid_o;
        pv_stall = stall_v;
        pv_pc    = bus.f_pc_o;
        pv_ir    = bus.f_ir_o;
        cyc++;
    endtask

    task automatic wait_valid(input string tag);
        int i = 0;
        while (!bus.f_valid_o && i < 20) begin
            step();
            i++;
        end
        chk(tag, bus.f_valid_o, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.im_data_i = '0; bus.im_valid_i = 1'b0; bus.f_stall_i = 1'b0;
        bus.x_bra_i = 1'b0; bus.x_bra_target_i = '0;

        // reset state
        step(); step();
        chk("rst_valid", bus.f_valid_o, 0);
        chk("rst_ir", bus.f_ir_o, 0);
        chk("rst_pc", bus.f_pc_o, 0);
        chk("rst_addr", bus.im_addr_o, RV);

        // L=1 streaming from the reset vector
        rst_v = 1'b0; lmin = 1; lmax = 1;
        step();
        chk("first_rd", bus.im_rd_o, 1);
        chk("first_addr", bus.im_addr_o, RV);
        step(); chk("lat_v0", bus.f_valid_o, 0);
        step(); chk("lat_v1", bus.f_valid_o, 1); chk("s_pc0", bus.f_pc_o, RV);
        step(); chk("s_pc1", bus.f_pc_o, RV + 32'd4);
        step(); chk("s_pc2", bus.f_pc_o, RV + 32'd8);
        repeat (5) step();

        // L=2 with a 5-cycle decode stall
        lmin = 2; lmax = 2;
        repeat (6) step();
        stall_v = 1'b1;
        repeat (5) step();
        stall_v = 1'b0;
        repeat (10) step();

        // redirect with two reads in flight (L=3)
        rst_v = 1'b1; step();
        rst_v = 1'b0; lmin = 3; lmax = 3;
        step(); step();
        bra_v = 1'b1; tgt_v = 32'h2000;
        step();
        chk("t3_inflight", rq_addr.size(), 2);
        bra_v = 1'b0;
        wait_valid("t3_wait");
        chk("t3_pc", bus.f_pc_o, 32'h2000);
        chk("t3_ir", bus.f_ir_o, mem_word(32'h2000));

        // redirect coinciding with a response and a pop (L=1)
        lmin = 1; lmax = 1;
        repeat (6) step();
        bra_v = 1'b1; tgt_v = 32'h3000;
        step();
        chk("t4_pre_vld", bus.f_valid_o, 1);
        bra_v = 1'b0;
        step();
        chk("t4_n1_vld", bus.f_valid_o, 0);
        chk("t4_n1_rd", bus.im_rd_o, 1);
        chk("t4_n1_addr", bus.im_addr_o, 32'h3000);
        step(); chk("t4_n2_vld", bus.f_valid_o, 0);
        step(); chk("t4_n3_vld", bus.f_valid_o, 1); chk("t4_n3_pc", bus.f_pc_o, 32'h3000);

        // address wrap, target low bits ignored
        repeat (4) step();
        bra_v = 1'b1; tgt_v = 32'hFFFF_FFFA;
        step();
        bra_v = 1'b0;
        step(); step();
        step(); chk("wrap0", bus.f_pc_o, 32'hFFFF_FFF8);
        step(); chk("wrap1", bus.f_pc_o, 32'hFFFF_FFFC);
        step(); chk("wrap2", bus.f_pc_o, 32'h0000_0000);

        // fill FIFO under stall, then reset mid-stream
        stall_v = 1'b1;
        repeat (6) step();
        chk("full_vld", bus.f_valid_o, 1);
        chk("full_rd", bus.im_rd_o, 0);
        rst_v = 1'b1; step();
        rst_v = 1'b0; stall_v = 1'b0;
        step();
        chk("mrst_vld", bus.f_valid_o, 0);
        chk("mrst_pc", bus.f_pc_o, 0);
        chk("mrst_ir", bus.f_ir_o, 0);
        chk("mrst_addr", bus.im_addr_o, RV);
        chk("mrst_rd", bus.im_rd_o, 1);
        step(); step();
        chk("mrst_pc0", bus.f_pc_o, RV);

        // random traffic
        repeat (3000) begin
            stall_v = ($urandom % 4) == 0;
            bra_v   = ($urandom % 20) == 0;
            tgt_v   = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            rst_v   = ($urandom % 300) == 0;
            if (($urandom % 200) == 0) begin
                lmin = 1;
                lmax = $urandom_range(4, 1);
            end
            step();
        end
        rst_v = 1'b0; bra_v = 1'b0; stall_v = 1'b0;
        repeat (10) step();
        chk("progress", pops > 300, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
